// File: rtl/fetch_queue_pkg.sv
// Shared processor constants: datapath width, NOP encoding and default
// fetch queue depth.
package fetch_queue_pkg;

    localparam int FQ_WORD_W = 16;
    localparam int FQ_DEPTH  = 4;
    localparam logic [FQ_WORD_W-1:0] FQ_NOP = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// Register-based FIFO between instruction fetch and decode, with redirect
// flush and a full-queue pop-and-push path.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int WORD_W = FQ_WORD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [WORD_W-1:0]        fetch_pc,
    input  logic [WORD_W-1:0]        fetch_instr,
    output logic                     fetch_ready,
    input  logic                     flush,
    output logic                     dec_valid,
    output logic [WORD_W-1:0]        dec_pc,
    output logic [WORD_W-1:0]        dec_instr,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stall_fetch
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_W-1:0] r_pc_mem    [DEPTH];
    logic [WORD_W-1:0] r_instr_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    // A full queue still accepts when the head leaves in the same cycle;
    // reset and flush discard the offer, so the handshake may complete.
    assign w_full      = (r_count == CW'(DEPTH));
    assign fetch_ready = reset || flush || !w_full || dec_ready;
    assign stall_fetch = !fetch_ready;

    assign dec_valid = (r_count != '0);
    assign w_push    = fetch_valid && fetch_ready && !flush;
    assign w_pop     = dec_valid && dec_ready && !flush;

    assign dec_pc    = dec_valid ? r_pc_mem[r_rd_ptr]    : WORD_W'(FQ_NOP);
    assign dec_instr = dec_valid ? r_instr_mem[r_rd_ptr] : WORD_W'(FQ_NOP);
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_pc_mem[r_wr_ptr]    <= fetch_pc;
            r_instr_mem[r_wr_ptr] <= fetch_instr;
        end
    end

    // Pointers rely on natural power-of-two wrap.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked
// every cycle, plus literal expectations at the key scenario points.
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int WORD_W = 16;

    typedef struct {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } entry_t;

    logic              clk;
    logic              reset;
    logic              fetch_valid;
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] fetch_instr;
    logic              fetch_ready;
    logic              flush;
    logic              dec_valid;
    logic [WORD_W-1:0] dec_pc;
    logic [WORD_W-1:0] dec_instr;
    logic              dec_ready;
    logic [2:0]        count;
    logic              stall_fetch;

    int     passCount  = 0;
    int     checkCount = 0;
    logic   checkEn    = 1'b0;
    entry_t modelQ[$];

    fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_instr   (dec_instr),
        .dec_ready   (dec_ready),
        .count       (count),
        .stall_fetch (stall_fetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the edge and return on the falling edge.
    task automatic applyStimulus(input logic rst, input logic fv, input logic [WORD_W-1:0] pc,
                                 input logic [WORD_W-1:0] instr, input logic dr, input logic fl);
        @(posedge clk);
        #1;
        reset       = rst;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = instr;
        dec_ready   = dr;
        flush       = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic dr);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, dr, 1'b0);
    endtask

    // Reference model: plain FIFO of accepted pairs, updated at each rising edge.
    always @(posedge clk) begin
        bit fr;
        bit doPop;
        bit doPush;
        if (reset || flush) begin
            modelQ.delete();
        end else begin
            fr     = (modelQ.size() < DEPTH) || dec_ready;
            doPop  = (modelQ.size() > 0) && dec_ready;
            doPush = fetch_valid && fr;
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back('{pc: fetch_pc, instr: fetch_instr});
        end
    end

    always @(negedge clk) begin
        logic              expReady;
        logic [WORD_W-1:0] expPc;
        logic [WORD_W-1:0] expInstr;
        if (checkEn) begin
            expReady = reset || flush || (modelQ.size() < DEPTH) || dec_ready;
            expPc    = (modelQ.size() > 0) ? modelQ[0].pc    : 16'h0000;
            expInstr = (modelQ.size() > 0) ? modelQ[0].instr : 16'h0000;
            checkOutput("model_count",       32'(count),       32'(modelQ.size()));
            checkOutput("model_dec_valid",   32'(dec_valid),   32'(modelQ.size() != 0));
            checkOutput("model_dec_pc",      32'(dec_pc),      32'(expPc));
            checkOutput("model_dec_instr",   32'(dec_instr),   32'(expInstr));
            checkOutput("model_fetch_ready", 32'(fetch_ready), 32'(expReady));
            checkOutput("model_stall_fetch", 32'(stall_fetch), 32'(!expReady));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        fetch_instr = '0;
        dec_ready   = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        checkEn = 1'b1;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checkOutput("rst_count",       32'(count),       32'd0);
        checkOutput("rst_dec_valid",   32'(dec_valid),   32'd0);
        checkOutput("rst_dec_pc",      32'(dec_pc),      32'h0000);
        checkOutput("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        checkOutput("rst_stall",       32'(stall_fetch), 32'd0);
        idle(1'b0);

        // Fill the queue without draining; first push is not visible the same cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
            if (i == 0) checkOutput("lat_push_cycle_valid", 32'(dec_valid), 32'd0);
            if (i == 1) begin
                checkOutput("lat_next_cycle_valid", 32'(dec_valid), 32'd1);
                checkOutput("lat_next_cycle_pc",    32'(dec_pc),    32'h0000);
            end
        end
        idle(1'b0);
        checkOutput("full_count",       32'(count),       32'd4);
        checkOutput("full_fetch_ready", 32'(fetch_ready), 32'd0);
        checkOutput("full_stall",       32'(stall_fetch), 32'd1);
        checkOutput("full_dec_pc",      32'(dec_pc),      32'h0000);
        checkOutput("full_dec_instr",   32'(dec_instr),   32'hA000);

        // Pop-and-push while full.
        applyStimulus(1'b0, 1'b1, 16'h0004, 16'hA004, 1'b1, 1'b0);
        checkOutput("pp_fetch_ready", 32'(fetch_ready), 32'd1);
        checkOutput("pp_count",       32'(count),       32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            checkOutput("pp_drain_pc",    32'(dec_pc),    32'(i + 1));
            checkOutput("pp_drain_instr", 32'(dec_instr), 32'hA001 + 32'(i));
        end
        idle(1'b0);
        checkOutput("pp_empty_count", 32'(count), 32'd0);

        // Flush with three queued and a simultaneous offer.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0030 + 16'(i), 16'hB030 + 16'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'hB040, 1'b1, 1'b1);
        checkOutput("fl_fetch_ready", 32'(fetch_ready), 32'd1);
        checkOutput("fl_head_pc",     32'(dec_pc),      32'h0030);
        idle(1'b1);
        checkOutput("fl_count",     32'(count),     32'd0);
        checkOutput("fl_dec_valid", 32'(dec_valid), 32'd0);
        checkOutput("fl_dec_instr", 32'(dec_instr), 32'h0000);
        idle(1'b1);
        checkOutput("fl_no_ghost", 32'(dec_valid), 32'd0);

        // Streaming push/pop across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0010 + 16'(i), 16'hC010 + 16'(i), 1'b1, 1'b0);
            if (i > 0) begin
                checkOutput("stream_pc",    32'(dec_pc), 32'h0010 + 32'(i - 1));
                checkOutput("stream_count", 32'(count),  32'd1);
            end
        end
        idle(1'b1);
        checkOutput("stream_last_pc", 32'(dec_pc), 32'h0019);
        idle(1'b1);
        checkOutput("stream_end_count", 32'(count), 32'd0);

        // Reset mid-operation with an offer pending.
        applyStimulus(1'b0, 1'b1, 16'h0050, 16'hD050, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0051, 16'hD051, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0052, 16'hD052, 1'b0, 1'b0);
        checkOutput("rmid_fetch_ready", 32'(fetch_ready), 32'd1);
        idle(1'b0);
        checkOutput("rmid_count",       32'(count),       32'd0);
        checkOutput("rmid_dec_valid",   32'(dec_valid),   32'd0);
        checkOutput("rmid_fetch_ready", 32'(fetch_ready), 32'd1);
        idle(1'b0);

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
